// File: rtl/inc16_arbiter.sv
// Round-robin arbiter sharing one 16-bit incrementer among NREQ valid/ready clients.
// The result lands in a one-deep output register, tagged with the client index and a wrap flag.

module inc16 (
   input  logic [15:0] a,
   output logic [15:0] y
);
   assign y = a + 16'd1;
endmodule

module inc16_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [16*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   output logic [15:0]          rsp_data,
   output logic [IDW-1:0]       rsp_id,
   output logic                 rsp_ovf,
   input  logic                 rsp_ready
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [15:0]    rsp_data_q, rsp_data_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic           rsp_ovf_q, rsp_ovf_d;

   logic           found_s;
   logic [IDW-1:0] winner_s;
   logic           can_accept_s;
   logic           accept_s;
   logic [15:0]    op_s;
   logic [15:0]    sum_s;

   // The incrementer has no carry-out, so wrap is detected from the operand itself.
   function automatic logic all_ones16(input logic [15:0] v);
      return &v;
   endfunction

   // Rotating priority search starting just after the last winner.
   always_comb begin : grant_search
      int idx;
      logic cand_valid;
      found_s    = 1'b0;
      winner_s   = '0;
      idx        = 0;
      cand_valid = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(ptr_q) + k;
         idx = (idx >= NREQ) ? (idx - NREQ) : idx;
         cand_valid = 1'b0;
         for (int i = 0; i < NREQ; i++) begin
            if (idx == i) begin
               cand_valid = req_valid[i];
            end else begin
               cand_valid = cand_valid;
            end
         end
         if (!found_s && cand_valid) begin
            found_s  = 1'b1;
            winner_s = IDW'(idx);
         end else begin
            found_s  = found_s;
            winner_s = winner_s;
         end
      end
   end

   // Handshake and operand mux; req_ready never depends on req_data.
   always_comb begin
      can_accept_s = (state_q == EMPTY) || rsp_ready;
      req_ready    = '0;
      op_s         = 16'h0000;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = !reset && can_accept_s && found_s && req_valid[i]
                        && (winner_s == IDW'(i));
         if (winner_s == IDW'(i)) begin
            op_s = req_data[16*i +: 16];
         end else begin
            op_s = op_s;
         end
      end
      accept_s = |req_ready;
   end

   inc16 u_inc16 (
      .a (op_s),
      .y (sum_s)
   );

   // Output-register state and capture of the accepted result.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      rsp_data_d = rsp_data_q;
      rsp_id_d   = rsp_id_q;
      rsp_ovf_d  = rsp_ovf_q;
      case (state_q)
         EMPTY:   state_d = accept_s ? FULL : EMPTY;
         FULL:    state_d = (rsp_ready && !accept_s) ? EMPTY : FULL;
         default: state_d = EMPTY;
      endcase
      if (accept_s) begin
         ptr_d      = winner_s;
         rsp_data_d = sum_s;
         rsp_id_d   = winner_s;
         rsp_ovf_d  = all_ones16(op_s);
      end else begin
         ptr_d      = ptr_q;
         rsp_data_d = rsp_data_q;
         rsp_id_d   = rsp_id_q;
         rsp_ovf_d  = rsp_ovf_q;
      end
   end

   // State registers; pointer resets to NREQ-1 so requester 0 is searched first.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= EMPTY;
         ptr_q      <= IDW'(NREQ - 1);
         rsp_data_q <= 16'h0000;
         rsp_id_q   <= '0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rsp_data_q <= rsp_data_d;
         rsp_id_q   <= rsp_id_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   assign rsp_valid = (state_q == FULL);
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_inc16_arbiter.sv
// Bench for inc16_arbiter: directed vector table, hand-written corner sequences,
// and a randomized run against a queue-level reference model.

module tb_inc16_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [63:0] req_data;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [1:0]  rsp_id;
   logic        rsp_ovf;
   logic        rsp_ready;

   int errors = 0;
   int checks = 0;

   inc16_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .rsp_ovf   (rsp_ovf),
      .rsp_ready (rsp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  v;
      logic [63:0] d;
      logic        r;
      logic [3:0]  rr;
      logic        ov;
      logic [15:0] od;
      logic [1:0]  oid;
      logic        oovf;
   } vec_t;

   vec_t tbl[26];

   localparam logic [63:0] PAT_A = {16'hFFFF, 16'h7FFF, 16'h00FF, 16'h0000};
   localparam logic [63:0] PAT_S = {16'h0000, 16'h0041, 16'h0000, 16'h0000};

   function automatic vec_t mk(input logic [3:0] v, input logic [63:0] d, input logic r,
                               input logic [3:0] rr, input logic ov, input logic [15:0] od,
                               input logic [1:0] oid, input logic oovf);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.rr = rr;
      t.ov = ov; t.od = od; t.oid = oid; t.oovf = oovf;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Called at a falling edge: apply inputs, check handshake, clock, check the result register.
   task automatic cyc(input string tag, input logic [3:0] v, input logic [63:0] d, input logic r,
                      input logic [3:0] rr, input logic ov, input logic [15:0] od,
                      input logic [1:0] oid, input logic oovf);
      req_valid = v;
      req_data  = d;
      rsp_ready = r;
      #1;
      chk({tag, " req_ready"}, {28'd0, req_ready}, {28'd0, rr});
      @(posedge clk);
      #1;
      chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, {31'd0, ov});
      if (ov) begin
         chk({tag, " rsp_data"}, {16'd0, rsp_data}, {16'd0, od});
         chk({tag, " rsp_id"}, {30'd0, rsp_id}, {30'd0, oid});
         chk({tag, " rsp_ovf"}, {31'd0, rsp_ovf}, {31'd0, oovf});
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      req_valid = 4'b0000;
      rsp_ready = 1'b0;
      reset     = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Reference model state for the random phase.
   logic        m_full;
   logic [15:0] m_data;
   logic [1:0]  m_id;
   logic        m_ovf;
   int          m_ptr;
   logic        pend[4];
   logic [15:0] pdata[4];
   int          waits[4];

   initial begin
      reset     = 1'b0;
      req_valid = 4'b0000;
      req_data  = 64'd0;
      rsp_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("reset rsp_id", {30'd0, rsp_id}, 32'd0);
      chk("reset rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
      req_valid = 4'b1111;
      #1;
      chk("reset req_ready", {28'd0, req_ready}, 32'd0);
      do_reset();

      // Directed vector table.
      for (int i = 0; i < 8; i++) begin
         case (i % 4)
            0:       tbl[i] = mk(4'b1111, PAT_A, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0, 1'b0);
            1:       tbl[i] = mk(4'b1111, PAT_A, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1, 1'b0);
            2:       tbl[i] = mk(4'b1111, PAT_A, 1'b1, 4'b0100, 1'b1, 16'h8000, 2'd2, 1'b0);
            default: tbl[i] = mk(4'b1111, PAT_A, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd3, 1'b1);
         endcase
      end
      tbl[8]  = mk(4'b0000, PAT_A, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
      tbl[9]  = mk(4'b0100, PAT_S, 1'b1, 4'b0100, 1'b1, 16'h0042, 2'd2, 1'b0);
      tbl[10] = mk(4'b0000, PAT_S, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
      tbl[11] = mk(4'b0000, PAT_S, 1'b0, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
      tbl[12] = mk(4'b0010, PAT_A, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1, 1'b0);
      tbl[13] = mk(4'b0000, PAT_A, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
      tbl[14] = mk(4'b0010, PAT_A, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1, 1'b0);
      tbl[15] = mk(4'b0000, PAT_A, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
      tbl[16] = mk(4'b0110, PAT_A, 1'b1, 4'b0100, 1'b1, 16'h8000, 2'd2, 1'b0);
      tbl[17] = mk(4'b1000, PAT_A, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd3, 1'b1);
      for (int i = 18; i < 23; i++) begin
         tbl[i] = mk(4'b1010, PAT_A, 1'b0, 4'b0000, 1'b1, 16'h0000, 2'd3, 1'b1);
      end
      tbl[23] = mk(4'b1010, PAT_A, 1'b1, 4'b0010, 1'b1, 16'h0100, 2'd1, 1'b0);
      tbl[24] = mk(4'b1000, PAT_A, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd3, 1'b1);
      tbl[25] = mk(4'b0000, PAT_A, 1'b1, 4'b0000, 1'b0, 16'h0000, 2'd0, 1'b0);
      for (int i = 0; i < 26; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].rr,
             tbl[i].ov, tbl[i].od, tbl[i].oid, tbl[i].oovf);
      end

      // Reset while holding 0x1235 discards it; requester 0 is first afterwards.
      do_reset();
      cyc("rst_mid load", 4'b0100, {16'h0000, 16'h1234, 32'd0}, 1'b0, 4'b0100,
          1'b1, 16'h1235, 2'd2, 1'b0);
      req_valid = 4'b1111;
      req_data  = PAT_A;
      rsp_ready = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_mid rsp_data", {16'd0, rsp_data}, 32'd0);
      chk("rst_mid rsp_id", {30'd0, rsp_id}, 32'd0);
      chk("rst_mid req_ready", {28'd0, req_ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      cyc("rst_mid first", 4'b1111, PAT_A, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0, 1'b0);

      // Requester 0 hogs; requester 3 still gets in, then order resumes at 0.
      do_reset();
      cyc("hog a", 4'b0001, PAT_A, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0, 1'b0);
      cyc("hog b", 4'b0001, PAT_A, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0, 1'b0);
      cyc("hog c", 4'b1001, PAT_A, 1'b1, 4'b1000, 1'b1, 16'h0000, 2'd3, 1'b1);
      cyc("hog d", 4'b0001, PAT_A, 1'b1, 4'b0001, 1'b1, 16'h0001, 2'd0, 1'b0);

      // Randomized run against the reference model.
      do_reset();
      m_full = 1'b0; m_data = 16'h0000; m_id = 2'd0; m_ovf = 1'b0; m_ptr = 3;
      for (int i = 0; i < 4; i++) begin
         pend[i] = 1'b0; pdata[i] = 16'h0000; waits[i] = 0;
      end
      for (int n = 0; n < 1500; n++) begin
         logic [3:0]  v;
         logic [63:0] d;
         logic        r;
         logic        can;
         int          win;
         logic [3:0]  exp_rr;
         logic [16:0] sum;
         d = 64'd0;
         for (int i = 0; i < 4; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i]  = 1'b1;
               waits[i] = 0;
               case ($urandom_range(0, 3))
                  0:       pdata[i] = 16'hFFFF;
                  1:       pdata[i] = 16'h7FFF;
                  default: pdata[i] = 16'($urandom);
               endcase
            end
            v[i] = pend[i];
            d[16*i +: 16] = pend[i] ? pdata[i] : 16'($urandom);
         end
         r = ($urandom_range(0, 3) != 0);
         req_valid = v;
         req_data  = d;
         rsp_ready = r;
         #1;
         can = !m_full || r;
         win = -1;
         for (int k = 1; k <= 4; k++) begin
            if (win < 0 && pend[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
         end
         exp_rr = (can && win >= 0) ? (4'b0001 << win) : 4'b0000;
         chk("rnd req_ready", {28'd0, req_ready}, {28'd0, exp_rr});
         chk("rnd rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
         if (m_full) begin
            chk("rnd rsp_data", {16'd0, rsp_data}, {16'd0, m_data});
            chk("rnd rsp_id", {30'd0, rsp_id}, {30'd0, m_id});
            chk("rnd rsp_ovf", {31'd0, rsp_ovf}, {31'd0, m_ovf});
         end
         if (exp_rr != 4'b0000) begin
            sum    = {1'b0, pdata[win]} + 17'd1;
            m_data = sum[15:0];
            m_ovf  = sum[16];
            m_id   = 2'(win);
            m_full = 1'b1;
            m_ptr  = win;
            chk("rnd fairness", {31'd0, (waits[win] < 4)}, 32'd1);
            pend[win] = 1'b0;
            for (int i = 0; i < 4; i++) begin
               if (pend[i]) waits[i]++;
            end
         end else if (r) begin
            m_full = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inc16_arbiter.md
# inc16_arbiter

Round-robin arbiter that time-shares one `inc16` incrementer among `NREQ` requesters over valid/ready handshakes. Each cycle, at most one requester's 16-bit operand is granted and passed through the shared `inc16`. The result is captured in a one-deep output register, tagged with the requester index. It sits between several counter/pointer clients (PC shadow, stack pointer, DMA address) and the single incrementer instance, so area stays at one `inc16`.

## Interface
- `NREQ`, 4: number of requesters; supported range 2..8.
- `IDW`, 2: width of requester index; must satisfy 2^IDW >= NREQ.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i presents an operand.
- `req_data`  in  16*NREQ  operand of requester i in bits [16i+15:16i].
- `req_ready`  out  NREQ  one-hot-or-zero; bit i high means requester i's operand is accepted this cycle.
- `rsp_valid`  out  1  output register holds a result.
- `rsp_data`  out  16  result, equal to operand + 1 mod 2^16.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_ovf`  out  1  operand was 0xFFFF; the result wrapped to 0x0000.
- `rsp_ready`  in  1  consumer accepts the result this cycle.

## Operation
- Exactly one `inc16` instance. Its input is muxed from the granted requester's `req_data` slice.
- Carry-out is not available from `inc16`. `rsp_ovf` is computed as the AND-reduction of the granted operand.
- Output FSM, 2 states:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on `rsp_ready` with no accept.
  - FULL -> FULL on `rsp_ready` with a same-cycle accept (back-to-back), or on `!rsp_ready`.
- `can_accept` = EMPTY or (FULL and `rsp_ready`).
- Grant: search `req_valid` starting at index `ptr`+1 mod NREQ, wrapping. The first set bit wins.
- `req_ready[i]` = `can_accept` and (i == winner) and `req_valid[i]`. This is combinational from `req_valid`, `rsp_ready` and state. There is no path from `req_data` into `req_ready`.
- On accept, on the same edge:
  - `ptr` <= winner.
  - `rsp_data` <= inc16(operand).
  - `rsp_id` <= winner.
  - `rsp_ovf` <= &operand.
- Fairness: a requester holding `req_valid` high is granted within NREQ accepts.
- Requesters must hold `req_valid`/`req_data` stable until `req_ready`. The arbiter samples operand data only in the accept cycle.
- While FULL and `!rsp_ready`, `rsp_data`/`rsp_id`/`rsp_ovf` hold stable.
- If no `req_valid` bit is set, there is no accept and `ptr` is unchanged.

## Timing
- Reset (async assert, released synchronously by the system) drives:
  - `rsp_valid`=0, `rsp_data`=0x0000, `rsp_id`=0, `rsp_ovf`=0.
  - `ptr`=NREQ-1, so requester 0 has first priority.
  - `req_ready`=0 while `reset` is high.
- Reset mid-transaction discards the held result immediately; no response is produced for it.
- Latency: operand accepted at edge N, result visible with `rsp_valid`=1 after edge N.
- Throughput: 1 result/cycle while `rsp_ready` is held high.
- When FULL and `rsp_ready`=0, `req_ready` is all-zero. The grant pointer does not advance.
- Wrap-around: operand 0xFFFF gives `rsp_data`=0x0000 and `rsp_ovf`=1. Operand 0x7FFF gives 0x8000 and `rsp_ovf`=0.

## Test plan
- **Reset mid-transaction.**
  - Assert `reset` while FULL with `rsp_data`=0x1235.
  - Required: `rsp_valid` drops to 0 asynchronously, `rsp_data`=0x0000, `rsp_id`=0.
  - After release, with all four requesters valid, requester 0 is granted first.
- **Single requester.**
  - Stimulus: requester 2 valid with 0x0041, `rsp_ready`=1.
  - Required: `req_ready`=4'b0100 for one cycle; next cycle `rsp_valid`=1, `rsp_data`=0x0042, `rsp_id`=2, `rsp_ovf`=0.
- **Round-robin.**
  - Stimulus: all 4 requesters held valid (operands 0x0000, 0x00FF, 0x7FFF, 0xFFFF), `rsp_ready`=1 for 8 cycles.
  - Required: `rsp_id` sequence 0,1,2,3,0,1,2,3.
  - Required data: 0x0001, 0x0100, 0x8000, 0x0000 with `rsp_ovf`=1 only for id 3.
- **Backpressure.**
  - Stimulus: `rsp_ready`=0 with a result held and requesters 1 and 3 valid.
  - Required: `req_ready`=0 and the `rsp_*` outputs stable for 5 cycles.
  - Raising `rsp_ready` drains the held result and accepts requester 1 on the same edge (back-to-back).
- **Fairness under a hog.**
  - Stimulus: requester 0 continuously valid; requester 3 raises valid once.
  - Required: requester 3 is granted within 4 accepts and the grant order resumes at 0.
- **Idle gaps.**
  - Stimulus: requests separated by idle cycles.
  - Required: no spurious `rsp_valid`; `ptr` is unchanged across idle cycles. After the last grant to 1, a request from 1 alone is granted; with 1 and 2 both valid, 2 wins.
